elevator_sequencer: RTL and testbench

Elevator car controller that sits directly upstream of the VGA controller and drives its `destination` and `sim_state` inputs in place of the free-running test counter. It latches floor call requests into a pending mask and moves a virtual car one floor at a time using SCAN (elevator) ordering. It opens the door at each requested floor and reports car position and motion state every cycle. All motion timing is counted in `tick` strobes, so the same RTL runs at pixel clock with a slow strobe or in simulation with `tick` held high.

---
 rtl/elevator_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_elevator_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_sequencer.sv
// -----------------------------------------------------------------------------
// elevator_sequencer
//
// Elevator car controller feeding the VGA controller's destination/sim_state
// inputs. Floor calls are latched into a pending mask. A virtual car moves one
// floor at a time in SCAN order and opens its door at each requested floor.
// All motion timing advances only on cycles where `tick` is high.
//
// Parameters
//   FLOORS      number of serviced floors (2..16)
//   MOVE_TICKS  ticks to travel one floor (>=1)
//   DOOR_TICKS  ticks the door stays open (>=1)
//
// Ports
//   clk          single clock (VGA pixel clock domain)
//   rst_n        synchronous active-low reset
//   tick         timing strobe; move/door counters advance only when high
//   call_req     per-floor call request, bit i = floor i (bits >= FLOORS ignored)
//   destination  registered pending-request mask
//   cur_floor    registered current car floor
//   sim_state    registered state: 00 IDLE, 01 UP, 10 DOWN, 11 DOOR
//
// Optional feature macro
//   DOOR_REOPEN_EN  a call for the current floor while the door is open
//                   restarts the door timer; otherwise it is absorbed.
// -----------------------------------------------------------------------------
module elevator_sequencer #(
    parameter int FLOORS     = 16,
    parameter int MOVE_TICKS = 8,
    parameter int DOOR_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [15:0] call_req,
    output logic [15:0] destination,
    output logic [3:0]  cur_floor,
    output logic [1:0]  sim_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_DOOR = 2'b11
    } state_t;

    typedef struct packed {
        state_t state;
        logic   pref_up;
    } decision_t;

    localparam int MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_TICKS - 1);
    localparam logic [DW-1:0] DOOR_LAST  = DW'(DOOR_TICKS - 1);
    localparam logic [15:0]   FLOOR_MASK = 16'((32'd1 << FLOORS) - 32'd1);

    state_t          r_state;
    logic [15:0]     r_pending;
    logic [3:0]      r_cur_floor;
    logic [MW-1:0]   r_move_cnt;
    logic [DW-1:0]   r_door_cnt;
    logic            r_pref_up;

    logic [15:0]     w_cur_onehot;
    logic [3:0]      w_next_floor;
    logic [15:0]     w_next_onehot;
    logic            w_arrive;
    logic            w_door_done;
    logic [15:0]     w_req;
    logic [15:0]     w_clear;
    decision_t       w_dec_here;
    decision_t       w_dec_next;

    // SCAN decision: keep going the preferred way while requests lie ahead,
    // otherwise reverse if anything is behind, otherwise stop.
    function automatic decision_t decide(input logic [15:0] pend,
                                         input logic [3:0]  f,
                                         input logic        pref_up);
        logic [15:0] above;
        logic [15:0] below;
        decision_t   d;
        above     = pend & (16'hFFFF << ({1'b0, f} + 5'd1));
        below     = pend & ((16'd1 << f) - 16'd1);
        d.state   = S_IDLE;
        d.pref_up = pref_up;
        if (pref_up) begin
            if (|above) begin
                d.state = S_UP;
            end else if (|below) begin
                d.state   = S_DOWN;
                d.pref_up = 1'b0;
            end
        end else begin
            if (|below) begin
                d.state = S_DOWN;
            end else if (|above) begin
                d.state   = S_UP;
                d.pref_up = 1'b1;
            end
        end
        return d;
    endfunction

    assign w_cur_onehot  = 16'd1 << r_cur_floor;
    // Only meaningful while moving; wraps harmlessly in other states.
    assign w_next_floor  = (r_state == S_UP) ? r_cur_floor + 4'd1 : r_cur_floor - 4'd1;
    assign w_next_onehot = 16'd1 << w_next_floor;
    assign w_arrive      = ((r_state == S_UP) || (r_state == S_DOWN)) && tick &&
                           (r_move_cnt == MOVE_LAST);
    assign w_door_done   = (r_state == S_DOOR) && tick && (r_door_cnt == DOOR_LAST);
    assign w_dec_here    = decide(r_pending, r_cur_floor, r_pref_up);
    assign w_dec_next    = decide(r_pending, w_next_floor, r_pref_up);

    // A call for the floor whose door is open is never recorded as pending.
    assign w_req = call_req & FLOOR_MASK &
                   ~((r_state == S_DOOR) ? w_cur_onehot : 16'd0);

`ifdef DOOR_REOPEN_EN
    logic w_door_call;
    assign w_door_call = (r_state == S_DOOR) && |(call_req & FLOOR_MASK & w_cur_onehot);
`endif

    // One-hot bit of the floor whose door opens on this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        w_clear = 16'd0;
        if (r_state == S_IDLE && |(r_pending & w_cur_onehot)) begin
            w_clear = w_cur_onehot;
        end else if (w_arrive && |(r_pending & w_next_onehot)) begin
            w_clear = w_next_onehot;
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pending   <= 16'd0;
            r_cur_floor <= 4'd0;
            r_move_cnt  <= '0;
            r_door_cnt  <= '0;
            r_pref_up   <= 1'b1;
        end else begin
            // Clear wins over a same-edge request for the serviced floor.
            r_pending <= (r_pending | w_req) & ~w_clear;
            case (r_state)
                S_IDLE: begin
                    if (|w_clear) begin
                        r_state    <= S_DOOR;
                        r_door_cnt <= '0;
                    end else begin
                        r_state   <= w_dec_here.state;
                        r_pref_up <= w_dec_here.pref_up;
                    end
                end
                S_UP, S_DOWN: begin
                    if (w_arrive) begin
                        r_cur_floor <= w_next_floor;
                        r_move_cnt  <= '0;
                        if (|w_clear) begin
                            r_state    <= S_DOOR;
                            r_door_cnt <= '0;
                        end else begin
                            r_state   <= w_dec_next.state;
                            r_pref_up <= w_dec_next.pref_up;
                        end
                    end else if (tick) begin
                        r_move_cnt <= r_move_cnt + MW'(1);
                    end
                end
                S_DOOR: begin
`ifdef DOOR_REOPEN_EN
                    if (w_door_call) begin
                        r_door_cnt <= '0;
                    end else if (w_door_done) begin
                        r_door_cnt <= '0;
                        r_state    <= w_dec_here.state;
                        r_pref_up  <= w_dec_here.pref_up;
                    end else if (tick) begin
                        r_door_cnt <= r_door_cnt + DW'(1);
                    end
`else
                    if (w_door_done) begin
                        r_door_cnt <= '0;
                        r_state    <= w_dec_here.state;
                        r_pref_up  <= w_dec_here.pref_up;
                    end else if (tick) begin
                        r_door_cnt <= r_door_cnt + DW'(1);
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign destination = r_pending;
    assign cur_floor   = r_cur_floor;
    assign sim_state   = r_state;

endmodule

// File: tb/tb_elevator_sequencer.sv
// -----------------------------------------------------------------------------
// tb_elevator_sequencer
//
// Self-checking bench for elevator_sequencer (FLOORS=16, MOVE_TICKS=8,
// DOOR_TICKS=4). A behavioural car model tracks floor, direction, elapsed
// travel/door ticks and a per-floor request array; every cycle the DUT outputs
// are compared against it. Directed scenarios add literal expectations, then a
// randomized phase exercises calls, tick gating and resets.
// Honours DOOR_REOPEN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_elevator_sequencer;

    localparam int FLOORS     = 16;
    localparam int MOVE_TICKS = 8;
    localparam int DOOR_TICKS = 4;

    localparam int ST_IDLE = 0;
    localparam int ST_UP   = 1;
    localparam int ST_DOWN = 2;
    localparam int ST_DOOR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] call_req = 16'd0;
    logic [15:0] destination;
    logic [3:0]  cur_floor;
    logic [1:0]  sim_state;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model of the car.
    int m_floor;
    int m_state;
    int m_moved;      // ticks of travel completed toward the next floor
    int m_opened;     // ticks the door has been open
    bit m_pref_up;
    bit m_pend[16];

    elevator_sequencer #(
        .FLOORS    (FLOORS),
        .MOVE_TICKS(MOVE_TICKS),
        .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .call_req   (call_req),
        .destination(destination),
        .cur_floor  (cur_floor),
        .sim_state  (sim_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SCAN choice from floor f: look for any request strictly above/below.
    task automatic m_decide(input int f);
        bit any_above = 1'b0;
        bit any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (m_pend[i] && i > f) any_above = 1'b1;
            if (m_pend[i] && i < f) any_below = 1'b1;
        end
        if (m_pref_up ? any_above : (!any_below && any_above)) begin
            m_state   = ST_UP;
            m_pref_up = 1'b1;
        end else if (any_below) begin
            m_state   = ST_DOWN;
            m_pref_up = 1'b0;
        end else begin
            m_state = ST_IDLE;
        end
    endtask

    task automatic m_reset();
        m_floor   = 0;
        m_state   = ST_IDLE;
        m_moved   = 0;
        m_opened  = 0;
        m_pref_up = 1'b1;
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic m_step(input logic r, input logic t, input logic [15:0] req);
        bit new_req[16];
        int served = -1;
        if (!r) begin
            m_reset();
            return;
        end
        for (int i = 0; i < 16; i++)
            new_req[i] = (i < FLOORS) && req[i] && !(m_state == ST_DOOR && i == m_floor);
        case (m_state)
            ST_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_state  = ST_DOOR;
                    m_opened = 0;
                    served   = m_floor;
                end else begin
                    m_decide(m_floor);
                end
            end
            ST_UP, ST_DOWN: begin
                if (t) begin
                    m_moved++;
                    if (m_moved == MOVE_TICKS) begin
                        m_floor = m_floor + ((m_state == ST_UP) ? 1 : -1);
                        m_moved = 0;
                        if (m_pend[m_floor]) begin
                            m_state  = ST_DOOR;
                            m_opened = 0;
                            served   = m_floor;
                        end else begin
                            m_decide(m_floor);
                        end
                    end
                end
            end
            default: begin
`ifdef DOOR_REOPEN_EN
                if (req[m_floor]) begin
                    m_opened = 0;
                end else if (t) begin
                    m_opened++;
                    if (m_opened == DOOR_TICKS) begin
                        m_opened = 0;
                        m_decide(m_floor);
                    end
                end
`else
                if (t) begin
                    m_opened++;
                    if (m_opened == DOOR_TICKS) begin
                        m_opened = 0;
                        m_decide(m_floor);
                    end
                end
`endif
            end
        endcase
        for (int i = 0; i < 16; i++)
            m_pend[i] = (m_pend[i] || new_req[i]) && (i != served);
    endtask

    task automatic compare_all();
        logic [15:0] exp_dest = 16'd0;
        for (int i = 0; i < 16; i++) exp_dest[i] = m_pend[i];
        check("destination", destination, exp_dest);
        check("cur_floor", {12'd0, cur_floor}, 16'(m_floor));
        check("sim_state", {14'd0, sim_state}, 16'(m_state));
    endtask

    // Apply inputs for one cycle (we sit at a falling edge), then compare.
    task automatic cyc(input logic r, input logic t, input logic [15:0] req);
        rst_n    = r;
        tick     = t;
        call_req = req;
        m_step(r, t, req);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_door(input int f, input int budget, input string name);
        int n = 0;
        while (!(cur_floor == 4'(f) && sim_state == 2'b11) && n < budget) begin
            cyc(1'b1, 1'b1, 16'd0);
            n++;
        end
        check(name, {15'd0, (cur_floor == 4'(f) && sim_state == 2'b11)}, 16'd1);
    endtask

    initial begin
        logic [15:0] req;
        logic        t;
        logic        r;
        m_reset();
        @(negedge clk);

        // Reset state.
        cyc(1'b0, 1'b1, 16'd0);
        cyc(1'b0, 1'b1, 16'd0);
        check("rst_dest", destination, 16'h0000);
        check("rst_floor", {12'd0, cur_floor}, 16'd0);
        check("rst_state", {14'd0, sim_state}, 16'd0);

        // Single call to floor 3.
        cyc(1'b1, 1'b1, 16'h0008);
        check("single_dest", destination, 16'h0008);
        cyc(1'b1, 1'b1, 16'd0);
        check("single_up", {14'd0, sim_state}, 16'd1);
        repeat (24) cyc(1'b1, 1'b1, 16'd0);
        check("single_floor", {12'd0, cur_floor}, 16'd3);
        check("single_door", {14'd0, sim_state}, 16'd3);
        check("single_clr", destination, 16'h0000);
        repeat (4) cyc(1'b1, 1'b1, 16'd0);
        check("single_idle", {14'd0, sim_state}, 16'd0);

        // Reset during travel, with a call presented while in reset.
        cyc(1'b1, 1'b1, 16'h0080);
        repeat (12) cyc(1'b1, 1'b1, 16'd0);
        cyc(1'b0, 1'b1, 16'h0010);
        cyc(1'b0, 1'b1, 16'h0010);
        cyc(1'b1, 1'b1, 16'd0);
        check("midrst_dest", destination, 16'h0000);
        check("midrst_floor", {12'd0, cur_floor}, 16'd0);
        check("midrst_state", {14'd0, sim_state}, 16'd0);

        // SCAN: upward car at floor 5 receives calls for 2 and 9.
        cyc(1'b1, 1'b1, 16'h0020);
        wait_door(5, 80, "scan_reach5");
        cyc(1'b1, 1'b1, 16'h0204);
        check("scan_dest0", destination, 16'h0204);
        wait_door(9, 120, "scan_reach9");
        check("scan_dest1", destination, 16'h0004);
        wait_door(2, 200, "scan_reach2");
        check("scan_dest2", destination, 16'h0000);

        // Top-floor boundary from floor 0.
        cyc(1'b0, 1'b1, 16'd0);
        cyc(1'b1, 1'b1, 16'h8000);
        wait_door(15, 200, "top_reach15");
        repeat (4) cyc(1'b1, 1'b1, 16'd0);
        check("top_idle", {14'd0, sim_state}, 16'd0);
        repeat (8) cyc(1'b1, 1'b1, 16'd0);
        check("top_stay_idle", {14'd0, sim_state}, 16'd0);
        check("top_floor", {12'd0, cur_floor}, 16'd15);

        // Door reopen at floor 4: pulse when the door count is 2.
        cyc(1'b1, 1'b1, 16'h0010);
        wait_door(4, 200, "reopen_reach4");
        cyc(1'b1, 1'b1, 16'd0);
        cyc(1'b1, 1'b1, 16'd0);
        cyc(1'b1, 1'b1, 16'h0010);
        check("reopen_bit4", {15'd0, destination[4]}, 16'd0);
        cyc(1'b1, 1'b1, 16'd0);
`ifdef DOOR_REOPEN_EN
        check("reopen_open", {14'd0, sim_state}, 16'd3);
        repeat (2) cyc(1'b1, 1'b1, 16'd0);
        check("reopen_still", {14'd0, sim_state}, 16'd3);
        cyc(1'b1, 1'b1, 16'd0);
`else
        check("reopen_closed", {14'd0, sim_state}, 16'd0);
        repeat (3) cyc(1'b1, 1'b1, 16'd0);
`endif
        check("reopen_end", {14'd0, sim_state}, 16'd0);

        // Tick gating mid-travel from floor 4 toward 10.
        cyc(1'b1, 1'b1, 16'h0400);
        cyc(1'b1, 1'b1, 16'd0);
        check("gate_up", {14'd0, sim_state}, 16'd1);
        repeat (12) cyc(1'b1, 1'b1, 16'd0);
        cyc(1'b1, 1'b0, 16'h2000);
        repeat (99) cyc(1'b1, 1'b0, 16'd0);
        check("gate_floor", {12'd0, cur_floor}, 16'd5);
        check("gate_state", {14'd0, sim_state}, 16'd1);
        check("gate_dest", destination, 16'h2400);
        repeat (3) cyc(1'b1, 1'b1, 16'd0);
        check("gate_hold", {12'd0, cur_floor}, 16'd5);
        cyc(1'b1, 1'b1, 16'd0);
        check("gate_arrive", {12'd0, cur_floor}, 16'd6);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            r   = ($urandom_range(0, 1499) != 0);
            t   = ($urandom_range(0, 9) < 8);
            req = 16'd0;
            if ($urandom_range(0, 14) == 0) req[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 59) == 0) req[$urandom_range(0, 15)] = 1'b1;
            if (m_state == ST_DOOR && $urandom_range(0, 7) == 0) req[m_floor] = 1'b1;
            cyc(r, t, req);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
